// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   - FSM state encoding
//   - op_sel codes for div/divu/mult/multu
//   - LO value written on divide-by-zero
package muldiv_ctrl_pkg;

  localparam int unsigned XLen   = 32;
  localparam int unsigned OpSelW = 2;
  localparam int unsigned CntW   = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StDivRun = 2'b01,
    StMulRun = 2'b10,
    StDone   = 2'b11
  } muldiv_state_e;

  localparam logic [OpSelW-1:0] OpDiv   = 2'b00;
  localparam logic [OpSelW-1:0] OpDivu  = 2'b01;
  localparam logic [OpSelW-1:0] OpMult  = 2'b10;
  localparam logic [OpSelW-1:0] OpMultu = 2'b11;

  localparam logic [XLen-1:0] DivZeroLo = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of EX-stage, divider, multiplier and HI/LO signals around muldiv_ctrl.
//   slave  : view of the controller itself
//   master : view of the surrounding EX stage / arithmetic units
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  // EX stage -> controller
  logic              op_valid;
  logic [OpSelW-1:0] op_sel;
  logic [XLen-1:0]   src_a;
  logic [XLen-1:0]   src_b;
  logic              ex_hold;
  logic              flush;
  // Divider
  logic              div_start;
  logic              div_signed;
  logic              div_annul;
  logic [XLen-1:0]   div_op_a;
  logic [XLen-1:0]   div_op_b;
  logic              div_ready;
  logic [2*XLen-1:0] div_result;
  // Multiplier
  logic              mul_signed;
  logic [XLen-1:0]   mul_op_a;
  logic [XLen-1:0]   mul_op_b;
  logic [2*XLen-1:0] mul_result;
  // Pipeline / HI-LO
  logic              stallreq;
  logic              hi_we;
  logic              lo_we;
  logic [XLen-1:0]   hi_wdata;
  logic [XLen-1:0]   lo_wdata;

  modport slave (
    input  op_valid, op_sel, src_a, src_b, ex_hold, flush,
    input  div_ready, div_result, mul_result,
    output div_start, div_signed, div_annul, div_op_a, div_op_b,
    output mul_signed, mul_op_a, mul_op_b,
    output stallreq, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport master (
    output op_valid, op_sel, src_a, src_b, ex_hold, flush,
    output div_ready, div_result, mul_result,
    input  div_start, div_signed, div_annul, div_op_a, div_op_b,
    input  mul_signed, mul_op_a, mul_op_b,
    input  stallreq, hi_we, lo_we, hi_wdata, lo_wdata
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the EX stage. Launches an external divider or
// fixed-latency multiplier, stalls PC..EX while it runs and writes HI/LO once.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - muldiv_ctrl_if.slave: EX-stage request, divider/multiplier
//          handshake, stall request and HI/LO write port
// Parameter MUL_LAT (1..7): cycles spent in MUL_RUN before the product is taken.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  muldiv_ctrl_if.slave  bus
);

  localparam logic [CntW-1:0] MulLatCnt = CntW'(MUL_LAT);

  muldiv_state_e   r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [XLen-1:0] r_op_a, w_op_a_d;
  logic [XLen-1:0] r_op_b, w_op_b_d;
  logic            r_signed, w_signed_d;
  logic [XLen-1:0] r_hi, w_hi_d;
  logic [XLen-1:0] r_lo, w_lo_d;
  // Set on entry to DONE so the HI/LO write happens only in its first cycle.
  logic            r_wr, w_wr_d;
  logic            w_is_div;

  assign w_is_div = (bus.op_sel == OpDiv) || (bus.op_sel == OpDivu);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_op_a_d   = r_op_a;
    w_op_b_d   = r_op_b;
    w_signed_d = r_signed;
    w_hi_d     = r_hi;
    w_lo_d     = r_lo;
    w_wr_d     = 1'b0;

    bus.stallreq   = 1'b0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_annul  = 1'b0;
    bus.div_op_a   = '0;
    bus.div_op_b   = '0;
    bus.mul_signed = 1'b0;
    bus.mul_op_a   = '0;
    bus.mul_op_b   = '0;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.hi_wdata   = '0;
    bus.lo_wdata   = '0;

    unique case (r_state)
      StIdle: begin
        if (bus.op_valid && !bus.flush) begin
          bus.stallreq = 1'b1;
          w_op_a_d     = bus.src_a;
          w_op_b_d     = bus.src_b;
          if (w_is_div) begin
            w_signed_d = (bus.op_sel == OpDiv);
            if (bus.src_b != '0) begin
              w_state_d = StDivRun;
            end else begin
              // Divide-by-zero bypasses the divider entirely.
              w_hi_d    = bus.src_a;
              w_lo_d    = DivZeroLo;
              w_wr_d    = 1'b1;
              w_state_d = StDone;
            end
          end else begin
            w_signed_d = (bus.op_sel == OpMult);
            w_cnt_d    = MulLatCnt;
            w_state_d  = StMulRun;
          end
        end
      end

      StDivRun: begin
        bus.stallreq   = 1'b1;
        bus.div_start  = 1'b1;
        bus.div_signed = r_signed;
        bus.div_op_a   = r_op_a;
        bus.div_op_b   = r_op_b;
        if (bus.flush) begin
          // Flush beats a coincident div_ready; the result is dropped.
          bus.div_annul = 1'b1;
          w_state_d     = StIdle;
        end else if (bus.div_ready) begin
          w_hi_d    = bus.div_result[2*XLen-1:XLen];
          w_lo_d    = bus.div_result[XLen-1:0];
          w_wr_d    = 1'b1;
          w_state_d = StDone;
        end
      end

      StMulRun: begin
        bus.stallreq   = 1'b1;
        bus.mul_signed = r_signed;
        bus.mul_op_a   = r_op_a;
        bus.mul_op_b   = r_op_b;
        w_cnt_d        = r_cnt - 1'b1;
        if (bus.flush) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end else if (r_cnt == CntW'(1)) begin
          w_hi_d    = bus.mul_result[2*XLen-1:XLen];
          w_lo_d    = bus.mul_result[XLen-1:0];
          w_wr_d    = 1'b1;
          w_state_d = StDone;
        end
      end

      StDone: begin
        if (r_wr && !bus.flush) begin
          bus.hi_we    = 1'b1;
          bus.lo_we    = 1'b1;
          bus.hi_wdata = r_hi;
          bus.lo_wdata = r_lo;
        end
        // Holding in DONE keeps the same EX instruction from restarting.
        if (bus.flush || !bus.ex_hold) begin
          w_state_d = StIdle;
        end
      end

      default: w_state_d = StIdle;
    endcase

    // Reset cycle: kill any pending write and tell the divider to abandon work.
    if (rst) begin
      bus.hi_we     = 1'b0;
      bus.lo_we     = 1'b0;
      bus.hi_wdata  = '0;
      bus.lo_wdata  = '0;
      bus.div_annul = (r_state == StDivRun);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_wr     <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_op_a   <= w_op_a_d;
      r_op_b   <= w_op_b_d;
      r_signed <= w_signed_d;
      r_hi     <= w_hi_d;
      r_lo     <= w_lo_d;
      r_wr     <= w_wr_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural divider/multiplier models,
// directed corner cases and randomized operations against an arithmetic model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int unsigned MulLat = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_LAT(MulLat)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
    int     sa;
    int     sb;
    longint la;
    longint lb;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (sel == OpDiv || sel == OpDivu) begin
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (sel == OpDiv) return {32'(sa % sb), 32'(sa / sb)};
      return {a % b, a / b};
    end
    if (sel == OpMult) return 64'(la * lb);
    return ua * ub;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Divider model: ready in the tb_div_lat-th consecutive div_start cycle.
  int   tb_div_lat  = 1;
  int   dcnt        = 0;
  logic force_ready = 1'b0;
  always @(posedge clk) begin
    if (rst || !bus.div_start) dcnt <= 0;
    else                       dcnt <= dcnt + 1;
  end
  assign bus.div_ready  = (bus.div_start && (dcnt == tb_div_lat - 1)) || force_ready;
  assign bus.div_result = ref_result({1'b0, ~bus.div_signed}, bus.div_op_a, bus.div_op_b);

  // Multiplier model: product of operands seen MulLat-1 cycles ago.
  logic [31:0] pa [MulLat-1];
  logic [31:0] pb [MulLat-1];
  logic        ps [MulLat-1];
  always @(posedge clk) begin
    pa[0] <= bus.mul_op_a;
    pb[0] <= bus.mul_op_b;
    ps[0] <= bus.mul_signed;
    for (int i = 1; i < MulLat - 1; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign bus.mul_result = ref_result({1'b1, ~ps[MulLat-2]}, pa[MulLat-2], pb[MulLat-2]);

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled mid-cycle.
  int          m_wr = 0, m_wr_cyc = 0, m_stall = 0, m_dstart = 0, m_dsigned = 0;
  int          m_annul = 0, m_viol = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  always @(negedge clk) begin
    if (bus.hi_we) begin
      m_wr     <= m_wr + 1;
      m_wr_cyc <= cyc;
      m_hi     <= bus.hi_wdata;
      m_lo     <= bus.lo_wdata;
    end
    if (bus.stallreq) m_stall <= m_stall + 1;
    if (bus.div_start) m_dstart <= m_dstart + 1;
    if (bus.div_start && bus.div_signed) m_dsigned <= m_dsigned + 1;
    if (bus.div_annul) m_annul <= m_annul + 1;
    if ((bus.hi_we != bus.lo_we) ||
        (!bus.hi_we && ((bus.hi_wdata | bus.lo_wdata) != 32'h0)) ||
        (!bus.div_start && ((bus.div_op_a | bus.div_op_b) != 32'h0 || bus.div_signed)))
      m_viol <= m_viol + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.op_valid = 1'b0;
    bus.op_sel   = '0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.ex_hold  = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 64'(bus.stallreq), 64'h0);
    check_eq({tag, "_ctl"}, {60'h0, bus.div_start, bus.div_signed, bus.div_annul,
                             bus.mul_signed}, 64'h0);
    check_eq({tag, "_we"}, {62'h0, bus.hi_we, bus.lo_we}, 64'h0);
    check_eq({tag, "_ops"}, {bus.div_op_a | bus.mul_op_a, bus.div_op_b | bus.mul_op_b}, 64'h0);
    check_eq({tag, "_wd"}, {bus.hi_wdata, bus.lo_wdata}, 64'h0);
  endtask

  // One full operation with stall, write timing, data and hold checks.
  task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int dlat, input int hold, input string tag);
    logic [63:0] exp;
    int          run, t0, b_wr, b_st, b_ds, b_sg;
    bit          real_div;
    real_div = (sel == OpDiv || sel == OpDivu) && (b != 32'h0);
    exp      = ref_result(sel, a, b);
    run      = (sel == OpMult || sel == OpMultu) ? MulLat : (real_div ? dlat : 0);
    tb_div_lat = dlat;
    b_wr = m_wr; b_st = m_stall; b_ds = m_dstart; b_sg = m_dsigned;
    bus.op_valid = 1'b1; bus.op_sel = sel; bus.src_a = a; bus.src_b = b; bus.ex_hold = 1'b0;
    t0 = cyc;
    step();
    // op_valid and operands wander while the unit is busy; must be ignored.
    for (int i = 0; i < run; i++) begin
      bus.op_valid = 1'($urandom);
      bus.op_sel   = 2'($urandom);
      bus.src_a    = $urandom;
      bus.src_b    = $urandom;
      step();
    end
    bus.op_valid = 1'b1; bus.op_sel = sel; bus.src_a = a; bus.src_b = b;
    for (int h = 0; h < hold; h++) begin
      bus.ex_hold = 1'b1;
      step();
    end
    bus.ex_hold = 1'b0; bus.op_valid = 1'b0;
    step();
    step();
    check_eq({tag, "_nwr"}, 64'(m_wr - b_wr), 64'd1);
    check_eq({tag, "_wcyc"}, 64'(m_wr_cyc), 64'(t0 + 1 + run));
    check_eq({tag, "_hi"}, 64'(m_hi), 64'(exp[63:32]));
    check_eq({tag, "_lo"}, 64'(m_lo), 64'(exp[31:0]));
    check_eq({tag, "_stall"}, 64'(m_stall - b_st), 64'(run + 1));
    check_eq({tag, "_dstart"}, 64'(m_dstart - b_ds), 64'(real_div ? dlat : 0));
    check_eq({tag, "_dsigned"}, 64'(m_dsigned - b_sg), 64'((real_div && sel == OpDiv) ? dlat : 0));
  endtask

  initial begin
    int b_wr, b_an, b_st, b_ds;
    logic [1:0]  sel;
    logic [31:0] a, b;

    drive_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    step();

    run_op(OpDivu, 32'd100, 32'd7, 32, 0, "divu_100_7");
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 4, 0, "div_neg");
    run_op(OpMult, 32'hFFFF_FFFF, 32'd2, 1, 0, "mult");
    run_op(OpMultu, 32'hFFFF_FFFF, 32'd2, 1, 0, "multu");
    run_op(OpDiv, 32'd5, 32'd0, 1, 0, "div_by0");
    run_op(OpDivu, 32'hDEAD_BEEF, 32'd0, 1, 2, "divu_by0");
    run_op(OpDivu, 32'd1000, 32'd9, 6, 4, "hold4");
    run_op(OpMult, 32'h1234_5678, 32'h9ABC_DEF0, 1, 3, "mult_hold");

    // Flush ten cycles into a divide, then a late div_ready must be ignored.
    b_wr = m_wr; b_an = m_annul; b_st = m_stall; b_ds = m_dstart;
    tb_div_lat = 32;
    bus.op_valid = 1'b1; bus.op_sel = OpDivu; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    step();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush   = 1'b0;
    force_ready = 1'b1;
    repeat (3) step();
    force_ready = 1'b0;
    step();
    check_eq("flush_annul", 64'(m_annul - b_an), 64'd1);
    check_eq("flush_nwr", 64'(m_wr - b_wr), 64'd0);
    check_eq("flush_stall", 64'(m_stall - b_st), 64'd11);
    check_eq("flush_dstart", 64'(m_dstart - b_ds), 64'd10);
    run_op(OpDivu, 32'd77, 32'd5, 3, 0, "after_flush");

    // Flush coincident with div_ready: result discarded.
    b_wr = m_wr; b_an = m_annul;
    tb_div_lat = 5;
    bus.op_valid = 1'b1; bus.op_sel = OpDiv; bus.src_a = 32'd77; bus.src_b = 32'd5;
    step();
    bus.op_valid = 1'b0;
    repeat (4) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (3) step();
    check_eq("flush_rdy_nwr", 64'(m_wr - b_wr), 64'd0);
    check_eq("flush_rdy_annul", 64'(m_annul - b_an), 64'd1);

    // Reset in the middle of a divide.
    b_wr = m_wr;
    tb_div_lat = 20;
    bus.op_valid = 1'b1; bus.op_sel = OpDivu; bus.src_a = 32'd500; bus.src_b = 32'd4;
    step();
    bus.op_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_annul", 64'(bus.div_annul), 64'd1);
    check_eq("rst_mid_we", 64'(bus.hi_we), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid_after");
    step();
    repeat (3) step();
    check_eq("rst_mid_nwr", 64'(m_wr - b_wr), 64'd0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      sel = 2'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      if (sel == OpDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(sel, a, b, int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), "rnd");
    end

    check_eq("protocol_viol", 64'(m_viol), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
